stage_layer_sched: RTL and testbench

- Layer scheduler for one stage_ctrl-based compute stage.
- Holds a small host-written table of per-layer configurations.
- On start, drives each layer's config onto the stage, flushes the stage between layers, and counts output beats to detect layer completion.
- Signals done after the last programmed layer. Sits between the host config interface and the stage's length/depth inputs and stage reset.

---
 rtl/stage_layer_sched.sv | 121 ++++++++++++
 tb/tb_stage_layer_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_layer_sched.sv
// Layer scheduler: steps a compute stage through a host-programmed table of
// per-layer configs, flushing the stage before each layer and counting output beats.
module stage_layer_sched #(
    parameter int LAYERS       = 8,
    parameter int LAYER_AW     = 3,
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_wr_vld,
    output logic                cfg_wr_rdy,
    input  logic [LAYER_AW-1:0] cfg_wr_addr,
    input  logic [10+CNT_W:0]   cfg_wr_data,
    input  logic [LAYER_AW:0]   num_layers,
    input  logic                start,
    input  logic                abort,
    input  logic                data_out_vld,
    output logic [2:0]          load_length,
    output logic [3:0]          load_depth,
    output logic [2:0]          bias_length,
    output logic                state_length,
    output logic                stage_reset,
    output logic [LAYER_AW-1:0] layer_index,
    output logic                busy,
    output logic                done
);
    localparam int DW = 11 + CNT_W;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [DW-1:0]      tbl [LAYERS];
    logic [CNT_W-1:0]   out_count;
    logic [CNT_W-1:0]   beat_cnt;
    logic [FW-1:0]      flush_cnt;
    logic [LAYER_AW:0]  nl_lat;
    logic [LAYER_AW:0]  nl_clamp;
    logic               wr_en;
    logic               layer_cmp;
    logic               layer_last;
    logic               active;

    assign wr_en      = cfg_wr_vld && (state == IDLE) &&
                        ({1'b0, cfg_wr_addr} < (LAYER_AW+1)'(LAYERS));
    assign nl_clamp   = (num_layers > (LAYER_AW+1)'(LAYERS)) ? (LAYER_AW+1)'(LAYERS) : num_layers;
    // An out_count of zero means the layer produces nothing: finish on the first RUN cycle.
    assign layer_cmp  = (out_count == '0) ||
                        (data_out_vld && (beat_cnt == out_count - 1'b1));
    assign layer_last = (({1'b0, layer_index} + 1'b1) == nl_lat);
    assign active     = (state == LOAD) || (state == FLUSH) || (state == RUN);

    assign cfg_wr_rdy  = (state == IDLE);
    assign stage_reset = (state != RUN);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_layers == '0) ? DONE : LOAD;
            LOAD:    state_nxt = abort ? IDLE : FLUSH;
            FLUSH:   if (abort) state_nxt = IDLE;
                     else if (flush_cnt == '0) state_nxt = RUN;
            RUN:     if (abort) state_nxt = IDLE;
                     else if (layer_cmp) state_nxt = layer_last ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Table is plain storage; its contents are undefined until the host writes them.
    always_ff @(posedge clk) begin
        if (wr_en) tbl[cfg_wr_addr] <= cfg_wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_length  <= '0;
            load_depth   <= '0;
            bias_length  <= '0;
            state_length <= 1'b0;
            out_count    <= '0;
            layer_index  <= '0;
            beat_cnt     <= '0;
            flush_cnt    <= '0;
            nl_lat       <= '0;
        end else if (abort && active) begin
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    nl_lat      <= nl_clamp;
                    layer_index <= '0;
                end
                LOAD: begin
                    {out_count, state_length, bias_length, load_depth, load_length} <= tbl[layer_index];
                    beat_cnt  <= '0;
                    flush_cnt <= FW'(FLUSH_CYCLES - 1);
                end
                FLUSH: if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
                RUN: begin
                    if (layer_cmp) begin
                        beat_cnt <= '0;
                        if (!layer_last) layer_index <= layer_index + 1'b1;
                    end else if (data_out_vld) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_layer_sched.sv
// Directed + randomized bench for stage_layer_sched; expected timelines come from
// a per-layer walk of the table model (LOAD, flush, beats, done).
module tb_stage_layer_sched;
    localparam int LAYERS = 8, LAYER_AW = 3, FLUSH_CYCLES = 4, CNT_W = 8;
    localparam int DW = 11 + CNT_W;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cfg_wr_vld = 1'b0;
    logic                cfg_wr_rdy;
    logic [LAYER_AW-1:0] cfg_wr_addr = '0;
    logic [DW-1:0]       cfg_wr_data = '0;
    logic [LAYER_AW:0]   num_layers = '0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                data_out_vld = 1'b0;
    logic [2:0]          load_length;
    logic [3:0]          load_depth;
    logic [2:0]          bias_length;
    logic                state_length;
    logic                stage_reset;
    logic [LAYER_AW-1:0] layer_index;
    logic                busy;
    logic                done;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] model [LAYERS];

    stage_layer_sched #(.LAYERS(LAYERS), .LAYER_AW(LAYER_AW),
                        .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_wr_vld(cfg_wr_vld), .cfg_wr_rdy(cfg_wr_rdy),
        .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .num_layers(num_layers),
        .start(start), .abort(abort), .data_out_vld(data_out_vld),
        .load_length(load_length), .load_depth(load_depth), .bias_length(bias_length),
        .state_length(state_length), .stage_reset(stage_reset), .layer_index(layer_index),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int oc, input int sl, input int bl,
                                         input int ld, input int ll);
        return {CNT_W'(oc), 1'(sl), 3'(bl), 4'(ld), 3'(ll)};
    endfunction

    task automatic chk_cfg(input string tag, input logic [DW-1:0] e);
        chk({tag, "_ll"}, 32'(load_length),  32'(e[2:0]));
        chk({tag, "_ld"}, 32'(load_depth),   32'(e[6:3]));
        chk({tag, "_bl"}, 32'(bias_length),  32'(e[9:7]));
        chk({tag, "_sl"}, 32'(state_length), 32'(e[10]));
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        cfg_wr_vld  = 1'b1;
        cfg_wr_addr = LAYER_AW'(a);
        cfg_wr_data = d;
        tick();
        cfg_wr_vld = 1'b0;
        if (a < LAYERS) model[a] = d;
    endtask

    // Runs a whole schedule and checks it cycle by cycle. ab_layer >= 0 aborts that
    // layer together with its final beat; noise drives ignored writes/starts during RUN.
    task automatic run(input int nl_req, input int ab_layer, input bit noise);
        int nl, oc, beats, cyc;
        nl = (nl_req > LAYERS) ? LAYERS : nl_req;
        num_layers = (LAYER_AW+1)'(nl_req);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_wr_vld = 1'b0;
        if (nl == 0) begin
            chk("zero_done", 32'(done), 1);
            chk("zero_srst", 32'(stage_reset), 1);
            chk("zero_busy", 32'(busy), 1);
            tick();
            chk("zero_done_off", 32'(done), 0);
            chk("zero_busy_off", 32'(busy), 0);
            chk("zero_srst2", 32'(stage_reset), 1);
            return;
        end
        for (int i = 0; i < nl; i++) begin
            chk("load_busy", 32'(busy), 1);
            chk("load_srst", 32'(stage_reset), 1);
            chk("load_idx",  32'(layer_index), i);
            chk("load_done", 32'(done), 0);
            if (i > 0) chk_cfg("load_hold", model[i-1]);
            tick();
            for (int f = 0; f < FLUSH_CYCLES; f++) begin
                chk("flush_srst", 32'(stage_reset), 1);
                chk("flush_idx",  32'(layer_index), i);
                chk_cfg("flush_cfg", model[i]);
                data_out_vld = 1'($urandom % 2);
                tick();
                data_out_vld = 1'b0;
            end
            oc = int'(model[i][DW-1:11]);
            beats = 0;
            cyc = 0;
            forever begin
                chk("run_srst", 32'(stage_reset), 0);
                chk("run_idx",  32'(layer_index), i);
                chk("run_rdy",  32'(cfg_wr_rdy), 0);
                chk_cfg("run_cfg", model[i]);
                if (oc == 0) begin
                    tick();
                    break;
                end
                data_out_vld = (cyc > 30) ? 1'b1 : 1'($urandom % 2);
                if (noise) begin
                    cfg_wr_vld  = 1'($urandom % 2);
                    cfg_wr_addr = LAYER_AW'($urandom);
                    cfg_wr_data = DW'($urandom);
                    start       = 1'($urandom % 2);
                end
                if (i == ab_layer && beats == oc - 1) begin
                    data_out_vld = 1'b1;
                    abort = 1'b1;
                    tick();
                    abort = 1'b0; data_out_vld = 1'b0; cfg_wr_vld = 1'b0; start = 1'b0;
                    chk("abort_busy", 32'(busy), 0);
                    chk("abort_rdy",  32'(cfg_wr_rdy), 1);
                    chk("abort_done", 32'(done), 0);
                    chk("abort_srst", 32'(stage_reset), 1);
                    chk_cfg("abort_cfg", model[i]);
                    tick();
                    chk("abort_done2", 32'(done), 0);
                    chk("abort_busy2", 32'(busy), 0);
                    return;
                end
                if (data_out_vld && beats == oc - 1) begin
                    tick();
                    data_out_vld = 1'b0; cfg_wr_vld = 1'b0; start = 1'b0;
                    break;
                end
                if (data_out_vld) beats++;
                cyc++;
                tick();
                data_out_vld = 1'b0; cfg_wr_vld = 1'b0; start = 1'b0;
            end
        end
        chk("end_done", 32'(done), 1);
        chk("end_busy", 32'(busy), 1);
        tick();
        chk("end_done_off", 32'(done), 0);
        chk("end_busy_off", 32'(busy), 0);
        chk("end_rdy", 32'(cfg_wr_rdy), 1);
    endtask

    initial begin
        int nl, ab;
        tick();
        tick();
        chk("rst_ll",   32'(load_length), 0);
        chk("rst_ld",   32'(load_depth), 0);
        chk("rst_bl",   32'(bias_length), 0);
        chk("rst_sl",   32'(state_length), 0);
        chk("rst_idx",  32'(layer_index), 0);
        chk("rst_srst", 32'(stage_reset), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdy",  32'(cfg_wr_rdy), 1);
        reset = 1'b0;
        tick();

        // single layer
        wr(0, mk(3, 1, 2, 5, 4));
        run(1, -1, 1'b0);

        // three layers with distinct configs
        wr(0, mk(2, 0, 1, 7, 1));
        wr(1, mk(1, 1, 3, 2, 2));
        wr(2, mk(4, 0, 5, 9, 3));
        run(3, -1, 1'b0);

        // zero-layer run
        run(0, -1, 1'b0);

        // abort on layer 1's final beat, then a clean rerun
        run(3, 1, 1'b0);
        run(3, -1, 1'b0);

        // writes and starts during RUN are ignored; rerun shows unchanged table
        run(3, -1, 1'b1);
        run(3, -1, 1'b0);

        // zero-beat layer between two normal layers
        wr(1, mk(0, 1, 6, 12, 5));
        run(3, -1, 1'b0);

        // full table with num_layers clamped from 9
        for (int a = 0; a < LAYERS; a++) wr(a, mk($urandom_range(0, 5), $urandom % 2,
            $urandom % 8, $urandom % 16, $urandom % 8));
        run(9, -1, 1'b0);

        // write in the same cycle as start is visible to the first LOAD
        cfg_wr_vld  = 1'b1;
        cfg_wr_addr = '0;
        cfg_wr_data = mk(2, 1, 7, 15, 6);
        model[0]    = cfg_wr_data;
        run(1, -1, 1'b0);

        // reset in the middle of a run
        num_layers = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_srst", 32'(stage_reset), 1);
        chk("mid_idx",  32'(layer_index), 0);
        chk("mid_ll",   32'(load_length), 0);
        chk("mid_ld",   32'(load_depth), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_rdy",  32'(cfg_wr_rdy), 1);
        tick();

        // randomized schedules
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 3; w++) wr($urandom % LAYERS, mk($urandom_range(0, 6),
                $urandom % 2, $urandom % 8, $urandom % 16, $urandom % 8));
            nl = $urandom_range(0, 9);
            ab = -1;
            if (nl > 0 && ($urandom % 3) == 0) begin
                ab = $urandom_range(0, ((nl > LAYERS) ? LAYERS : nl) - 1);
                if (model[ab][DW-1:11] == '0) ab = -1;
            end
            run(nl, ab, 1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
